quadrature_step_gen: RTL and testbench
======================================

# quadrature_step_gen

- Transmit-side counterpart of the team's quadrature decoder tile: turns step/direction commands into a clean two-phase A/B quadrature waveform, so the decoder (or an external motor/encoder interface) can be driven and tested from a single Tiny Tapeout tile.
- Includes input synchronizers, step-edge detection, a programmable transition-rate prescaler, a one-deep pending-step buffer, a 4-bit position counter and an index output.

## Interface

**Parameters**
- SYNC_STAGES, 2, number of synchronizer flops on every io_in control bit (bit 1 excluded).

**Ports** (standard tile pins io_in[7:0] input, io_out[7:0] output)
- io_in[0]  in  1  clk; all flops rise-edge triggered.
- io_in[1]  in  1  rst_n; synchronous, active-low, not synchronized.
- io_in[2]  in  1  step; a rising edge requests one quadrature transition.
- io_in[3]  in  1  dir; 1 = forward (A leads B, pos increments), 0 = reverse.
- io_in[4]  in  1  run; 1 = free-running transitions at the prescaled rate.
- io_in[7:5]  in  3  rate; transition period P = 2^rate cycles (1..128).
- io_out[0]  out  1  A phase.
- io_out[1]  out  1  B phase.
- io_out[2]  out  1  busy; high for the P cycles following each transition.
- io_out[3]  out  1  index; high while pos == 0.
- io_out[7:4]  out  4  pos[3:0], signed-agnostic position, wraps modulo 16.

## Operation

- **Sync:** step, dir, run and rate each pass through SYNC_STAGES flops, giving step_s, dir_s, run_s, rate_s. step_d is step_s delayed one cycle. step_rise = step_s & ~step_d.
- **Phase outputs:** A/B are a registered decode of pos[1:0]: 0→AB=00, 1→10, 2→11, 3→01. Forward order is 00→10→11→01→00; reverse is the inverse. Any transition changes exactly one of A/B.
- **Transition:** pos ← pos ± 1, using dir_s sampled in the same cycle. Wrap is F→0 and 0→F.
- **FSM states:**
  - IDLE:
    - If run_s, or step_rise, transition at the next edge, load cnt = P−1 and go to HOLD.
  - HOLD (busy = 1):
    - cnt decrements each cycle.
    - When cnt == 0 in HOLD: if pending or run_s, transition, reload cnt = P−1 and stay in HOLD (pending consumed first; run_s alone also suffices). Otherwise go to IDLE.
- **Pending:**
  - step_rise in HOLD with run_s = 0 sets pending.
  - step_rise while pending is already set is dropped.
  - step_rise while run_s = 1 is ignored and not recorded.
- **Mid-operation changes:**
  - A rate change during HOLD takes effect at the next reload.
  - run_s falling during HOLD completes the current hold, then goes to IDLE unless pending is set.
- **Simultaneous events:** step_rise in the same cycle HOLD expires with pending = 0 is taken as the next transition, as if pending were set.
- **Reset:** while rst_n = 0 at an edge, all flops clear, including synchronizers, step_d, cnt, pending and FSM (→ IDLE). Reset mid-HOLD aborts the hold and discards pending.
- **Output reset values:** A = 0, B = 0, busy = 0, pos = 0, index = 1, i.e. io_out = 0x08.

## Timing

- **Step latency:** step rising before edge 1 gives step_s at edge 2 (SYNC_STAGES = 2) and step_rise during cycle 2–3. A/B, pos and busy update at edge 3.
- **busy:** asserted for exactly P cycles starting at the transition edge.
- **Spacing:** minimum transition spacing is exactly P cycles. In run mode transitions are spaced exactly P cycles.
- **index:** registered with pos and changes on the same edge.
- **After reset release with run held high:** first transition at edge 3 after the first edge sampling rst_n = 1.
- **Outputs:** all outputs are registered, with no combinational path from io_in to io_out.

## Test plan

- **Reset:** rst_n = 0 for 2 cycles with random other inputs → io_out = 0x08 at the edge after reset. It must stay 0x08 until a step or run occurs.
- **Single forward step, rate = 0, dir = 1:**
  - One step pulse → io_out = 0x15 at edge 3 (A = 1, busy, pos = 1).
  - 0x11 one cycle later.
  - No further change.
- **Four reverse steps, rate = 1, dir = 0, pulses 6 cycles apart:**
  - AB sequence 01, 11, 10, 00; pos F, E, D, C.
  - index drops at the first transition.
  - busy high 2 cycles per step.
- **Run mode, rate = 2 (P = 4), dir = 1:**
  - Transitions every 4 cycles.
  - After 16 transitions pos = 0, AB = 00 and index is high for 4 cycles.
  - Then deassert run → exactly one hold completes, then IDLE with busy = 0.
- **Pending, rate = 7 (P = 128), three step pulses 10 cycles apart:**
  - Exactly two transitions, 128 cycles apart.
  - Third pulse dropped; final pos = 2.
- **Reset mid-HOLD in run mode (rate = 3), rst_n low 1 cycle with run held high:**
  - io_out = 0x08 after the reset edge.
  - First new transition at edge 3 after release; pos = 1.

Source files
------------

// File: rtl/quadrature_step_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : quadrature_step_gen_if
//  Description : Tile pin bundle for the quadrature step generator.
//                io_in carries clk/rst_n on bits 1:0 (also routed as plain
//                ports to the core) and the step/dir/run/rate commands on
//                bits 7:2. io_out carries A, B, busy, index and pos[3:0].
//  Ports       : io_in[7:0]  - tile inputs  (driven by the master)
//                io_out[7:0] - tile outputs (driven by the slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface quadrature_step_gen_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input  io_out);
    modport slave  (input  io_in, output io_out);
endinterface
`default_nettype wire

// File: rtl/quadrature_step_gen.sv
`default_nettype none
// ============================================================================
//  Module      : quadrature_step_gen
//  Description : Step/direction to two-phase A/B quadrature generator.
//                Commands are synchronized, step edges detected, and each
//                accepted command produces exactly one quadrature transition
//                followed by a hold of P = 2^rate cycles. One step arriving
//                during a hold is buffered; run mode transitions every P
//                cycles. A 4-bit position counter drives the A/B decode and
//                the index flag.
//  Parameters  : SYNC_STAGES - synchronizer depth on io_in[7:2]
//  Ports       : clk            - rising-edge clock (tile pin io_in[0])
//                rst_n          - synchronous active-low reset (io_in[1])
//                tile.io_in[2]  - step, rising edge requests a transition
//                tile.io_in[3]  - dir, 1 = forward (A leads B, pos + 1)
//                tile.io_in[4]  - run, free-running transitions
//                tile.io_in[7:5]- rate, hold period P = 2^rate cycles
//                tile.io_out[0] - A phase
//                tile.io_out[1] - B phase
//                tile.io_out[2] - busy, high for the P cycles after a
//                                 transition
//                tile.io_out[3] - index, high while pos == 0
//                tile.io_out[7:4] - pos, wraps modulo 16
//  Revision    : 1.0 - initial release
// ============================================================================
module quadrature_step_gen #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    quadrature_step_gen_if.slave        tile
);

    localparam int CTRL_W = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. Every command bit goes through the same number
    // of stages so dir is always aligned with the step edge it qualifies.
    // Bits 1:0 of io_in are clk/rst_n and arrive on the dedicated ports.
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] r_sync [SYNC_STAGES];
    logic [CTRL_W-1:0] w_ctrl_s;
    logic              w_unused_pins;

    assign w_unused_pins = ^tile.io_in[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= tile.io_in[7:2];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_ctrl_s = r_sync[SYNC_STAGES-1];

    logic       w_step_s;
    logic       w_dir_s;
    logic       w_run_s;
    logic [2:0] w_rate_s;

    assign w_step_s = w_ctrl_s[0];
    assign w_dir_s  = w_ctrl_s[1];
    assign w_run_s  = w_ctrl_s[2];
    assign w_rate_s = w_ctrl_s[5:3];

    // ------------------------------------------------------------------
    // Step edge detection
    // ------------------------------------------------------------------
    logic r_step_d;
    logic w_step_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= w_step_s;
        end
    end

    assign w_step_rise = w_step_s & ~r_step_d;

    // Hold counter reload value P-1 = 2^rate - 1, formed as a mask of the
    // low 'rate' bits. Sampled only at reload, so a rate change mid-hold
    // applies from the next transition on.
    logic [6:0] w_reload;
    assign w_reload = ~(7'h7f << w_rate_s);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_cnt;
    logic [6:0] w_cnt_next;
    logic       r_pending;
    logic       w_pending_next;
    logic       w_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 7'd0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pending_next = r_pending;
        w_fire         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_run_s || w_step_rise) begin
                    w_fire       = 1'b1;
                    w_cnt_next   = w_reload;
                    w_state_next = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (r_cnt == 7'd0) begin
                    // Last hold cycle: a buffered step is consumed here, and
                    // a step edge landing exactly now counts as if buffered.
                    w_pending_next = 1'b0;
                    if (r_pending || w_run_s || w_step_rise) begin
                        w_fire     = 1'b1;
                        w_cnt_next = w_reload;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 7'd1;
                    // Only one step is buffered; further edges are dropped.
                    // Step edges in run mode are ignored entirely.
                    if (w_step_rise && !w_run_s) begin
                        w_pending_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Position counter and registered outputs. Outputs are computed from
    // the next position so pos, A/B and index all change on one edge.
    // ------------------------------------------------------------------
    logic [3:0] r_pos;
    logic [3:0] w_pos_next;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_index;
    logic [1:0] w_ba_next;

    // Gray decode of pos[1:0] into {B, A}: 00 -> 10 -> 11 -> 01 as AB,
    // so consecutive positions differ in exactly one phase.
    function automatic logic [1:0] phase_of(input logic [1:0] p);
        logic [1:0] ba;
        case (p)
            2'd0:    ba = 2'b00;
            2'd1:    ba = 2'b01;
            2'd2:    ba = 2'b11;
            default: ba = 2'b10;
        endcase
        return ba;
    endfunction

    always_comb begin
        w_pos_next = r_pos;
        if (w_fire) begin
            w_pos_next = w_dir_s ? (r_pos + 4'd1) : (r_pos - 4'd1);
        end
    end

    assign w_ba_next = phase_of(w_pos_next[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_index <= 1'b1;
        end else begin
            r_pos   <= w_pos_next;
            r_a     <= w_ba_next[0];
            r_b     <= w_ba_next[1];
            r_busy  <= (w_state_next == ST_HOLD);
            r_index <= (w_pos_next == 4'd0);
        end
    end

    assign tile.io_out = {r_pos, r_index, r_busy, r_b, r_a};

endmodule
`default_nettype wire

// File: tb/tb_quadrature_step_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quadrature_step_gen
//  Description : Self-checking bench for quadrature_step_gen. A cycle-level
//                model tracks position, remaining busy cycles and the step
//                buffer from the behavioural rules; outputs are compared on
//                every falling edge, and directed scenarios add literal
//                expectations at hand-computed edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quadrature_step_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step;
    logic       dir;
    logic       run;
    logic [2:0] rate;

    quadrature_step_gen_if tile ();

    assign tile.io_in = {rate, run, dir, step, rst_n, clk};

    quadrature_step_gen #(
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tile (tile.slave)
    );

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0] m_exp;

    function automatic logic [7:0] expected_out(input int pos, input bit busy);
        logic [1:0] ba;
        logic [3:0] p4;
        p4 = pos[3:0];
        case (pos % 4)
            0:       ba = 2'b00;
            1:       ba = 2'b01;
            2:       ba = 2'b11;
            default: ba = 2'b10;
        endcase
        return {p4, (pos == 0), busy, ba};
    endfunction

    initial begin
        int         m_pos;
        int         m_left;
        int         period;
        bit         m_pend;
        bit         fire;
        bit         rise;
        logic [5:0] d0, d1, d2, cur;
        m_pos  = 0;
        m_left = 0;
        m_pend = 0;
        d0 = '0; d1 = '0; d2 = '0;
        m_exp = 8'h08;
        forever begin
            @(posedge clk);
            cur = {rate, run, dir, step};
            if (!rst_n) begin
                m_pos  = 0;
                m_left = 0;
                m_pend = 0;
                d0 = '0; d1 = '0; d2 = '0;
            end else begin
                // Inputs seen by the core lag the pins by two edges.
                rise   = d1[0] && !d2[0];
                period = 1 << d1[5:3];
                fire   = 0;
                if (m_left <= 1) begin
                    fire   = d1[2] || rise || m_pend;
                    m_pend = 0;
                    m_left = fire ? period : 0;
                end else begin
                    m_left = m_left - 1;
                    if (rise && !d1[2]) m_pend = 1;
                end
                if (fire) m_pos = d1[1] ? (m_pos + 1) % 16 : (m_pos + 15) % 16;
                d2 = d1; d1 = d0; d0 = cur;
            end
            m_exp = expected_out(m_pos, m_left != 0);
        end
    end

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 0;
    int         lit_req = 0;
    int         lit_ack = 0;
    logic [7:0] lit_val;
    string      lit_name;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checks++;
                if (tile.io_out !== m_exp) begin
                    errors++;
                    $display("FAIL model_cycle t=%0t io_out=%02h expected %02h",
                             $time, tile.io_out, m_exp);
                end
            end
            if (lit_req != lit_ack) begin
                lit_ack = lit_req;
                checks++;
                if (tile.io_out !== lit_val) begin
                    errors++;
                    $display("FAIL %s t=%0t io_out=%02h expected %02h",
                             lit_name, $time, tile.io_out, lit_val);
                end
                checks++;
                if (m_exp !== lit_val) begin
                    errors++;
                    $display("FAIL %s_model t=%0t model=%02h expected %02h",
                             lit_name, $time, m_exp, lit_val);
                end
            end
        end
    end

    // Wait 'edges' rising edges, then have io_out checked at the following
    // falling edge; returns at that falling edge.
    task automatic expect_io(input int edges, input logic [7:0] val, input string name);
        repeat (edges) @(posedge clk);
        #1;
        lit_val  = val;
        lit_name = name;
        lit_req  = lit_req + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step  = 1'b0;
        run   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        step  = 1'($urandom);
        dir   = 1'($urandom);
        run   = 1'($urandom);
        rate  = 3'($urandom);
        @(negedge clk);
        chk_en = 1;
        expect_io(1, 8'h08, "reset_value");
        rst_n = 1'b1;
        step = 1'b0; run = 1'b0; dir = 1'b0; rate = 3'd0;
        expect_io(5, 8'h08, "idle_after_reset");

        // Single forward step, P = 1
        dir = 1'b1; rate = 3'd0; step = 1'b1;
        expect_io(3, 8'h15, "fwd_step");
        expect_io(1, 8'h11, "fwd_step_done");
        step = 1'b0;
        expect_io(4, 8'h11, "fwd_no_more");

        // Four reverse steps, P = 2, pulses 6 cycles apart
        do_reset();
        dir = 1'b0; rate = 3'd1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] v;
            case (k)
                0:       v = 8'hF6;
                1:       v = 8'hE7;
                2:       v = 8'hD5;
                default: v = 8'hC4;
            endcase
            step = 1'b1;
            expect_io(3, v, "rev_step");
            step = 1'b0;
            expect_io(1, v, "rev_busy");
            expect_io(1, v & 8'hFB, "rev_idle");
            @(negedge clk);
        end

        // Run mode, P = 4
        do_reset();
        run = 1'b1; rate = 3'd2; dir = 1'b1;
        expect_io(3, 8'h15, "run_first");
        expect_io(60, 8'h0C, "run_wrap16");
        run = 1'b0;
        expect_io(3, 8'h0C, "run_last_hold");
        expect_io(1, 8'h08, "run_stop_idle");
        expect_io(4, 8'h08, "run_stays_idle");

        // Pending buffer, P = 128, three pulses 10 cycles apart
        do_reset();
        dir = 1'b1; rate = 3'd7; step = 1'b1;
        expect_io(3, 8'h15, "pend_first");
        step = 1'b0;
        repeat (7) @(negedge clk);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (7) @(negedge clk);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        expect_io(107, 8'h15, "pend_hold1_end");
        expect_io(1, 8'h27, "pend_second");
        expect_io(127, 8'h27, "pend_hold2_end");
        expect_io(1, 8'h23, "pend_done");
        expect_io(5, 8'h23, "pend_third_dropped");

        // Reset in the middle of a run-mode hold, P = 8
        do_reset();
        run = 1'b1; rate = 3'd3; dir = 1'b1;
        expect_io(3, 8'h15, "mid_first");
        expect_io(2, 8'h15, "mid_busy");
        rst_n = 1'b0;
        expect_io(1, 8'h08, "mid_reset");
        rst_n = 1'b1;
        expect_io(2, 8'h08, "mid_wait");
        expect_io(1, 8'h15, "mid_restart");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
